// File: rtl/bcd_pkg.sv
// Shared BCD constants and the nibble validity check used by counters and display drivers.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit: loads a sanitised value or steps up/down with 9<->0 rollover.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             up,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    output logic [BCD_W-1:0] dig,
    output logic             at_max,
    output logic             at_min
);

    logic [BCD_W-1:0] dig_q;
    logic [BCD_W-1:0] dig_d;

    assign at_max = (dig_q == BCD_MAX);
    assign at_min = (dig_q == BCD_MIN);
    assign dig    = dig_q;

    always_comb begin
        dig_d = dig_q;
        if (ld) begin
            // Non-BCD load nibbles collapse to 0 so no digit ever exceeds 9.
            dig_d = is_bcd(ld_val) ? ld_val : BCD_MIN;
        end else if (step) begin
            if (up) begin
                dig_d = at_max ? BCD_MIN : dig_q + 4'd1;
            end else begin
                dig_d = at_min ? BCD_MAX : dig_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig_q <= BCD_MIN;
        end else begin
            dig_q <= dig_d;
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit up/down BCD counter with validated parallel load, terminal count,
// registered wrap pulse and registered load-error pulse.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cnt_en,
    input  logic                    up,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] d,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic [DIGITS-2:0]       en,
    output logic                    tc,
    output logic                    wrap,
    output logic                    err
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] bad_nib;
    logic              count;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;

    assign count = cnt_en & ~load;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .reset  (reset),
            .step   (step[i]),
            .up     (up),
            .ld     (load),
            .ld_val (d[BCD_W*i +: BCD_W]),
            .dig    (q[BCD_W*i +: BCD_W]),
            .at_max (at_max[i]),
            .at_min (at_min[i])
        );

        assign term[i]    = up ? at_max[i] : at_min[i];
        assign bad_nib[i] = ~is_bcd(d[BCD_W*i +: BCD_W]);

        // A digit steps only when every lower digit is at its rollover value.
        if (i == 0) begin : g_lsd
            assign step[i] = count;
        end else begin : g_upper
            assign step[i] = count & (&term[i-1:0]);
        end
    end

    assign en = step[DIGITS-1:1];
    assign tc = &term;

    always_comb begin
        wrap_d = count & tc;
        err_d  = load & (|bad_nib);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench: 6-, 4- and 2-digit counters share stimulus; a monitor pops expectations.
module tb_bcd_counter_n;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cnt_en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [23:0] d = 24'h0;

    logic [23:0] q6;
    logic [4:0]  en6;
    logic        tc6, wrap6, err6;
    logic [15:0] q4;
    logic [2:0]  en4;
    logic        tc4, wrap4, err4;
    logic [7:0]  q2;
    logic [0:0]  en2;
    logic        tc2, wrap2, err2;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(6)) u_dut6 (
        .clk(clk), .reset(reset), .cnt_en(cnt_en), .up(up), .load(load), .d(d),
        .q(q6), .en(en6), .tc(tc6), .wrap(wrap6), .err(err6)
    );
    bcd_counter_n u_dut4 (
        .clk(clk), .reset(reset), .cnt_en(cnt_en), .up(up), .load(load), .d(d[15:0]),
        .q(q4), .en(en4), .tc(tc4), .wrap(wrap4), .err(err4)
    );
    bcd_counter_n #(.DIGITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .cnt_en(cnt_en), .up(up), .load(load), .d(d[7:0]),
        .q(q2), .en(en2), .tc(tc2), .wrap(wrap2), .err(err2)
    );

    typedef struct {
        string       name;
        logic [23:0] q6;
        logic [15:0] q4;
        logic [7:0]  q2;
        logic [2:0]  wrap;
        logic [2:0]  err;
        logic [2:0]  tc;
        logic [4:0]  en6;
        logic [2:0]  en4;
        logic        en2;
        bit          hand;
        logic [15:0] hq;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: counter values as integers; index 0 = 6 digits, 1 = 4, 2 = 2.
    int       mv[3] = '{0, 0, 0};
    int       nd[3] = '{6, 4, 2};
    logic [2:0] mwrap = 3'b000;
    logic [2:0] merr = 3'b000;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic model_tc(input int k);
        return up ? (mv[k] == pow10(nd[k]) - 1) : (mv[k] == 0);
    endfunction

    function automatic logic [4:0] model_en(input int k);
        logic [4:0] r = '0;
        for (int i = 1; i < nd[k]; i++) begin
            int p = pow10(i);
            r[i-1] = cnt_en & ~load & (up ? (mv[k] % p == p - 1) : (mv[k] % p == 0));
        end
        return r;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int full = pow10(nd[k]);
            if (load) begin
                int  v = 0;
                logic bad = 1'b0;
                for (int i = 0; i < nd[k]; i++) begin
                    logic [3:0] nib = d[4*i +: 4];
                    if (nib > 4'd9) bad = 1'b1;
                    else v = v + int'(nib) * pow10(i);
                end
                mv[k] = v;
                merr[k] = bad;
                mwrap[k] = 1'b0;
            end else if (cnt_en) begin
                merr[k] = 1'b0;
                if (up) begin
                    mwrap[k] = (mv[k] == full - 1);
                    mv[k] = (mv[k] + 1) % full;
                end else begin
                    mwrap[k] = (mv[k] == 0);
                    mv[k] = (mv[k] + full - 1) % full;
                end
            end else begin
                mwrap[k] = 1'b0;
                merr[k] = 1'b0;
            end
        end
    endtask

    task automatic push_exp(input string nm, input bit hand, input logic [15:0] hq);
        exp_t        e;
        logic [23:0] b;
        logic [4:0]  enm;
        e.name = nm;
        b = to_bcd(mv[0]); e.q6 = b;
        b = to_bcd(mv[1]); e.q4 = b[15:0];
        b = to_bcd(mv[2]); e.q2 = b[7:0];
        e.wrap = mwrap;
        e.err = merr;
        for (int k = 0; k < 3; k++) e.tc[k] = model_tc(k);
        enm = model_en(0); e.en6 = enm;
        enm = model_en(1); e.en4 = enm[2:0];
        enm = model_en(2); e.en2 = enm[0];
        e.hand = hand;
        e.hq = hq;
        sb.push_back(e);
    endtask

    task automatic drive(input logic ce, input logic u, input logic ld, input logic [23:0] dv,
                         input string nm, input bit hand, input logic [15:0] hq);
        @(negedge clk);
        cnt_en = ce;
        up = u;
        load = ld;
        d = dv;
        model_edge();
        push_exp(nm, hand, hq);
    endtask

    // Drops reset between edges, holds it, then releases with counting paused.
    task automatic reset_pulse(input string nm, input int cycles);
        @(negedge clk);
        #2;
        mv = '{0, 0, 0};
        mwrap = 3'b000;
        merr = 3'b000;
        push_exp(nm, 1'b1, 16'h0000);
        reset = 1'b0;
        repeat (cycles) @(negedge clk);
        cnt_en = 1'b0;
        load = 1'b0;
        reset = 1'b1;
    endtask

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: outputs are presented after every clock edge and on reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".q6"}, q6, e.q6);
                check({e.name, ".q4"}, {8'h0, q4}, {8'h0, e.q4});
                check({e.name, ".q2"}, {16'h0, q2}, {16'h0, e.q2});
                check({e.name, ".wrap"}, {21'h0, wrap2, wrap4, wrap6}, {21'h0, e.wrap});
                check({e.name, ".err"}, {21'h0, err2, err4, err6}, {21'h0, e.err});
                check({e.name, ".tc"}, {21'h0, tc2, tc4, tc6}, {21'h0, e.tc});
                check({e.name, ".en6"}, {19'h0, en6}, {19'h0, e.en6});
                check({e.name, ".en4"}, {21'h0, en4}, {21'h0, e.en4});
                check({e.name, ".en2"}, {23'h0, en2}, {23'h0, e.en2});
                if (e.hand) check({e.name, ".q4_hand"}, {8'h0, q4}, {8'h0, e.hq});
            end
        end
    end

    initial begin
        // Reset, then count up 16 edges
        reset_pulse("t1_reset", 2);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 1'b1, 1'b0, 24'h0, $sformatf("t1_up%0d", k), (k == 16), 16'h0016);
        end

        // Up-count wrap through all nines
        drive(1'b0, 1'b1, 1'b1, 24'h999998, "t2_load", 1'b1, 16'h9998);
        drive(1'b1, 1'b1, 1'b0, 24'h0, "t2_to_tc", 1'b1, 16'h9999);
        drive(1'b1, 1'b1, 1'b0, 24'h0, "t2_wrap", 1'b1, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 24'h0, "t2_hold", 1'b1, 16'h0000);

        // Down-count wrap through zero
        drive(1'b1, 1'b0, 1'b0, 24'h0, "t3_down_wrap", 1'b1, 16'h9999);
        drive(1'b1, 1'b0, 1'b0, 24'h0, "t3_down", 1'b1, 16'h9998);
        drive(1'b0, 1'b0, 1'b0, 24'h0, "t3_hold", 1'b1, 16'h9998);

        // Load validation
        drive(1'b0, 1'b1, 1'b1, 24'h0012A4, "t4_bad_load", 1'b1, 16'h1204);
        drive(1'b0, 1'b1, 1'b1, 24'h000457, "t4_good_load", 1'b1, 16'h0457);
        drive(1'b0, 1'b1, 1'b0, 24'h0, "t4_hold", 1'b1, 16'h0457);

        // Load priority and direction toggling
        drive(1'b0, 1'b1, 1'b1, 24'h000199, "t5_load199", 1'b1, 16'h0199);
        drive(1'b1, 1'b1, 1'b1, 24'h005000, "t5_load_wins", 1'b1, 16'h5000);
        drive(1'b0, 1'b1, 1'b1, 24'h000500, "t5_load500", 1'b1, 16'h0500);
        drive(1'b1, 1'b0, 1'b0, 24'h0, "t5_dn", 1'b1, 16'h0499);
        drive(1'b1, 1'b1, 1'b0, 24'h0, "t5_up", 1'b1, 16'h0500);
        drive(1'b1, 1'b0, 1'b0, 24'h0, "t5_dn2", 1'b1, 16'h0499);

        // Async reset mid-cycle with an err pulse pending
        drive(1'b0, 1'b1, 1'b1, 24'h000734, "t6_load", 1'b1, 16'h0734);
        drive(1'b1, 1'b1, 1'b1, 24'h00F734, "t6_bad_load", 1'b1, 16'h0734);
        reset_pulse("t6_async_reset", 2);
        drive(1'b1, 1'b1, 1'b0, 24'h0, "t6_resume1", 1'b1, 16'h0001);
        drive(1'b1, 1'b1, 1'b0, 24'h0, "t6_resume2", 1'b1, 16'h0002);
        drive(1'b1, 1'b1, 1'b0, 24'h0, "t6_resume3", 1'b1, 16'h0003);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
